// File: rtl/compress_pkg.sv
// Shared tag codes and the per-tag payload size for the compress pipeline.
package compress_pkg;

    localparam logic [1:0] TAG_ZERO  = 2'd0;
    localparam logic [1:0] TAG_MATCH = 2'd1;
    localparam logic [1:0] TAG_HALF  = 2'd2;
    localparam logic [1:0] TAG_RAW   = 2'd3;

    // Payload size of a tagged word, in half-words.
    function automatic logic [1:0] tag_halves(input logic [1:0] tag);
        case (tag)
            TAG_HALF: tag_halves = 2'd1;
            TAG_RAW:  tag_halves = 2'd2;
            default:  tag_halves = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/compress_pipe_word_classifier.sv
// Classifies one word against its reference and produces its tag, half count
// and zero-padded payload (lower half only for HALF, full word for RAW).
module word_classifier import compress_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2
) (
    input  logic [DATA_WIDTH-1:0] w,
    input  logic [DATA_WIDTH-1:0] r,
    input  logic                  bypass,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic [1:0]            halves,
    output logic [DATA_WIDTH-1:0] payload
);

    localparam int HW = DATA_WIDTH / 2;

    logic [1:0] code;

    always_comb begin
        code = TAG_RAW;
        if (bypass)                                 code = TAG_RAW;
        else if (w == '0)                           code = TAG_ZERO;
        else if (w == r)                            code = TAG_MATCH;
        else if (w[DATA_WIDTH-1:HW] == r[DATA_WIDTH-1:HW]) code = TAG_HALF;

        tag     = TAG_WIDTH'(code);
        halves  = tag_halves(code);
        payload = '0;
        if (code == TAG_RAW)       payload = w;
        else if (code == TAG_HALF) payload[HW-1:0] = w[HW-1:0];
    end

endmodule

// File: rtl/compress_pipe.sv
// Two-stage word compressor: S1 holds per-word classification, S2 holds the
// compacted LSB-first beat. Valid/ready on both sides plus saturating stats.
module compress_pipe import compress_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int STAT_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_bypass,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]  in_data,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]  in_ref,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*NUM_DATA-1:0]  out_data,
    output logic [TAG_WIDTH*NUM_DATA-1:0]   out_tag,
    output logic [LEN_WIDTH-1:0]            out_len,
    output logic                            out_last,
    input  logic                            stat_clr,
    output logic [STAT_WIDTH-1:0]           stat_beats,
    output logic [STAT_WIDTH-1:0]           stat_halves
);

    localparam int HW = DATA_WIDTH / 2;
    localparam int BW = DATA_WIDTH * NUM_DATA;

    logic [NUM_DATA-1:0][TAG_WIDTH-1:0]  cls_tag, s1_tag_d, s1_tag_q;
    logic [NUM_DATA-1:0][1:0]            cls_hlv, s1_hlv_d, s1_hlv_q;
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0] cls_pay, s1_pay_d, s1_pay_q;
    logic                                s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
    logic                                s2_valid_d, s2_valid_q;
    logic [BW-1:0]                       out_data_d, out_data_q, pack_data;
    logic [TAG_WIDTH*NUM_DATA-1:0]       out_tag_d, out_tag_q;
    logic [LEN_WIDTH-1:0]                out_len_d, out_len_q, pack_len;
    logic                                out_last_d, out_last_q;
    logic [STAT_WIDTH-1:0]               stat_beats_d, stat_beats_q;
    logic [STAT_WIDTH-1:0]               stat_halves_d, stat_halves_q;
    logic [STAT_WIDTH:0]                 halves_sum;
    logic                                s1_ready, s2_ready;

    for (genvar i = 0; i < NUM_DATA; i++) begin : g_word
        word_classifier #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_cls (
            .w       (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .r       (in_ref[i*DATA_WIDTH +: DATA_WIDTH]),
            .bypass  (cfg_bypass),
            .tag     (cls_tag[i]),
            .halves  (cls_hlv[i]),
            .payload (cls_pay[i])
        );
    end

    // Each payload lands at the running half-word offset; payloads are
    // zero-padded so OR-ing keeps unused bits at 0.
    always_comb begin
        pack_data = '0;
        pack_len  = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            pack_data = pack_data | (BW'(s1_pay_q[i]) << (pack_len * HW));
            pack_len  = pack_len + LEN_WIDTH'(s1_hlv_q[i]);
        end
    end

    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        s1_ready   = !s1_valid_q || s2_ready;

        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_tag_d   = s1_tag_q;
        s1_hlv_d   = s1_hlv_q;
        s1_pay_d   = s1_pay_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_last_d = in_last;
                s1_tag_d  = cls_tag;
                s1_hlv_d  = cls_hlv;
                s1_pay_d  = cls_pay;
            end
        end

        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        out_len_d  = out_len_q;
        out_last_d = out_last_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = pack_data;
                out_tag_d  = s1_tag_q;
                out_len_d  = pack_len;
                out_last_d = s1_last_q;
            end
        end
    end

    always_comb begin
        halves_sum    = {1'b0, stat_halves_q} + (STAT_WIDTH+1)'(out_len_q);
        stat_beats_d  = stat_beats_q;
        stat_halves_d = stat_halves_q;
        if (stat_clr) begin
            stat_beats_d  = '0;
            stat_halves_d = '0;
        end else if (s2_valid_q && out_ready) begin
            if (stat_beats_q != '1) stat_beats_d = stat_beats_q + 1'b1;
            stat_halves_d = halves_sum[STAT_WIDTH] ? '1 : halves_sum[STAT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_tag_q      <= '0;
            s1_hlv_q      <= '0;
            s1_pay_q      <= '0;
            s2_valid_q    <= 1'b0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
            out_len_q     <= '0;
            out_last_q    <= 1'b0;
            stat_beats_q  <= '0;
            stat_halves_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s1_tag_q      <= s1_tag_d;
            s1_hlv_q      <= s1_hlv_d;
            s1_pay_q      <= s1_pay_d;
            s2_valid_q    <= s2_valid_d;
            out_data_q    <= out_data_d;
            out_tag_q     <= out_tag_d;
            out_len_q     <= out_len_d;
            out_last_q    <= out_last_d;
            stat_beats_q  <= stat_beats_d;
            stat_halves_q <= stat_halves_d;
        end
    end

    assign in_ready    = s1_ready;
    assign out_valid   = s2_valid_q;
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign out_len     = out_len_q;
    assign out_last    = out_last_q;
    assign stat_beats  = stat_beats_q;
    assign stat_halves = stat_halves_q;

endmodule

// File: tb/tb_compress_pipe.sv
// Directed bench for compress_pipe: classification vectors, backpressure,
// statistics (including a narrow-counter instance for saturation) and reset.
module tb_compress_pipe;

    logic         clk, reset, cfg_bypass, in_valid, in_last, out_ready, stat_clr;
    logic [255:0] in_data, in_ref;
    logic         in_ready, out_valid, out_last;
    logic [255:0] out_data;
    logic [15:0]  out_tag;
    logic [7:0]   out_len;
    logic [31:0]  stat_beats, stat_halves;

    logic         s_in_ready, s_out_valid, s_out_last;
    logic [255:0] s_out_data;
    logic [15:0]  s_out_tag;
    logic [7:0]   s_out_len;
    logic [3:0]   s_stat_beats, s_stat_halves;

    int n_chk = 0;
    int n_err = 0;

    compress_pipe dut (
        .clk(clk), .reset(reset), .cfg_bypass(cfg_bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ref(in_ref), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_len(out_len), .out_last(out_last), .stat_clr(stat_clr),
        .stat_beats(stat_beats), .stat_halves(stat_halves)
    );

    compress_pipe #(.STAT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .cfg_bypass(cfg_bypass),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_ref(in_ref), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_tag(s_out_tag),
        .out_len(s_out_len), .out_last(s_out_last), .stat_clr(stat_clr),
        .stat_beats(s_stat_beats), .stat_halves(s_stat_halves)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One beat with out_ready high: invisible after 1 edge, visible after 2.
    task automatic send_chk(input string nm, input logic [255:0] din, input logic [255:0] rf,
                            input logic byp, input logic [15:0] etag, input logic [7:0] elen,
                            input logic [255:0] edat);
        in_data = din; in_ref = rf; cfg_bypass = byp; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat"}, 256'(out_valid), 256'(1'b0));
        @(posedge clk); #1;
        chk({nm, "_vld"},  256'(out_valid), 256'(1'b1));
        chk({nm, "_tag"},  256'(out_tag),   256'(etag));
        chk({nm, "_len"},  256'(out_len),   256'(elen));
        chk({nm, "_data"}, out_data,        edat);
        @(posedge clk); #1;
    endtask

    // Back-to-back stream of n identical beats, then drain.
    task automatic stream(input logic [255:0] din, input logic [255:0] rf, input logic byp, input int n);
        in_data = din; in_ref = rf; cfg_bypass = byp; in_last = 1'b0; in_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_bp(input int k);
        in_data = '0;
        in_data[31:0] = 32'hC0DE0000 + 32'(k);
        in_ref = '0; cfg_bypass = 1'b0; in_last = (k == 3);
    endtask

    logic [255:0] v_t3_d, v_t3_r, v_mix_d, v_mix_r, v_raw, v_a5;
    logic [31:0]  got_w [4];
    logic         got_l [4];
    int           got, k;
    logic         acc_in;

    initial begin
        reset = 1'b0; cfg_bypass = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; stat_clr = 1'b0; in_data = '0; in_ref = '0;

        v_t3_d = '0; v_t3_r = '0;
        v_t3_d[31:0] = 32'h12345678; v_t3_r[31:0] = 32'h1234FFFF;
        v_t3_d[63:32] = 32'hDEADBEEF;
        v_mix_d = '0; v_mix_r = '0;
        v_mix_r[31:0]    = 32'h12345678;
        v_mix_d[63:32]   = 32'hAAAA0001; v_mix_r[63:32]   = 32'hAAAA9999;
        v_mix_d[95:64]   = 32'h11112222; v_mix_r[95:64]   = 32'h33332222;
        v_mix_d[127:96]  = 32'h55555555; v_mix_r[127:96]  = 32'h55555555;
        v_mix_d[159:128] = 32'h0000BEEF; v_mix_r[159:128] = 32'h00001234;
        for (int i = 0; i < 8; i++) begin
            v_raw[i*32 +: 32] = 32'h01010101 * 32'(i + 1);
            v_a5[i*32 +: 32]  = 32'hA5A5A5A5;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid),   256'(1'b0));
        chk("rst_in_ready",  256'(in_ready),    256'(1'b1));
        chk("rst_out_data",  out_data,          256'(0));
        chk("rst_out_tag",   256'(out_tag),     256'(0));
        chk("rst_out_len",   256'(out_len),     256'(0));
        chk("rst_out_last",  256'(out_last),    256'(1'b0));
        chk("rst_beats",     256'(stat_beats),  256'(0));
        chk("rst_halves",    256'(stat_halves), 256'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        send_chk("zero",   '0,      '1,      1'b0, 16'h0000, 8'd0,  '0);
        send_chk("match",  v_a5,    v_a5,    1'b0, 16'h5555, 8'd0,  '0);
        send_chk("t3",     v_t3_d,  v_t3_r,  1'b0, 16'h000E, 8'd3,  256'(48'hDEADBEEF5678));
        send_chk("mix",    v_mix_d, v_mix_r, 1'b0, 16'h0278, 8'd4,  256'(64'hBEEF111122220001));
        send_chk("allraw", v_raw,   '1,      1'b0, 16'hFFFF, 8'd16, v_raw);
        send_chk("byp0",   '0,      '1,      1'b1, 16'hFFFF, 8'd16, '0);
        send_chk("bypraw", v_raw,   v_raw,   1'b1, 16'hFFFF, 8'd16, v_raw);

        // Backpressure: downstream stalled for 5 cycles, then released.
        k = 0; got = 0;
        set_bp(0); in_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            #1;
            if (cyc >= 2 && cyc < 5) begin
                chk("bp_in_ready", 256'(in_ready),    256'(1'b0));
                chk("bp_valid",    256'(out_valid),   256'(1'b1));
                chk("bp_stable",   256'(out_data[31:0]), 256'(32'hC0DE0000));
            end
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got_w[got] = out_data[31:0];
                got_l[got] = out_last;
                got++;
            end
            @(posedge clk); #1;
            if (acc_in) begin
                k++;
                if (k < 4) set_bp(k);
                else in_valid = 1'b0;
            end
        end
        chk("bp_count", 256'(got), 256'(4));
        for (int j = 0; j < 4; j++) begin
            chk("bp_order", 256'(got_w[j]), 256'(32'hC0DE0000 + 32'(j)));
            chk("bp_last",  256'(got_l[j]), 256'(j == 3));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Statistics, with saturation on the 4-bit instance.
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        chk("clr_beats", 256'(stat_beats), 256'(0));
        stream(v_t3_d, v_t3_r, 1'b0, 3);
        chk("st_beats",    256'(stat_beats),    256'(3));
        chk("st_halves",   256'(stat_halves),   256'(9));
        chk("sat_beats3",  256'(s_stat_beats),  256'(3));
        chk("sat_halves9", 256'(s_stat_halves), 256'(9));
        stream('0, '0, 1'b1, 1);
        chk("sat_halves",  256'(s_stat_halves), 256'(4'hF));
        chk("st_halves25", 256'(stat_halves),   256'(25));
        stream(v_t3_d, v_t3_r, 1'b0, 12);
        chk("st_beats16",  256'(stat_beats),    256'(16));
        chk("st_halves61", 256'(stat_halves),   256'(61));
        chk("sat_beats",   256'(s_stat_beats),  256'(4'hF));
        chk("sat_halves2", 256'(s_stat_halves), 256'(4'hF));

        // Clear coinciding with an output handshake.
        in_data = v_t3_d; in_ref = v_t3_r; cfg_bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clrhs_valid", 256'(out_valid), 256'(1'b1));
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        chk("clrhs_beats",  256'(stat_beats),  256'(0));
        chk("clrhs_halves", 256'(stat_halves), 256'(0));
        @(posedge clk); #1;
        chk("clrhs_after",  256'(stat_beats),  256'(0));
        chk("clrhs_empty",  256'(out_valid),   256'(1'b0));

        // Reset in the middle of a running stream.
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_valid", 256'(out_valid),  256'(1'b1));
        chk("mid_beats", 256'(stat_beats), 256'(1));
        #2 reset = 1'b0;
        #1;
        chk("arst_valid",  256'(out_valid),   256'(1'b0));
        chk("arst_beats",  256'(stat_beats),  256'(0));
        chk("arst_halves", 256'(stat_halves), 256'(0));
        chk("arst_len",    256'(out_len),     256'(0));
        chk("arst_data",   out_data,          256'(0));
        chk("arst_ready",  256'(in_ready),    256'(1'b1));
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/compress_pipe.md
Name: compress_pipe

Overview:
Parametrised, pipelined successor to the fixed 8x32 compressor. It classifies each of NUM_DATA input words against a per-word reference word and generates the 2-bit tags itself; callers no longer supply tags. It then compacts the surviving payload into a dense LSB-first output beat. It sits between the data source and the packed-stream writer, with valid/ready handshakes on both sides, a bypass mode and saturating statistics counters.

Parameters:
DATA_WIDTH, 32, word width in bits; must be even.
NUM_DATA, 8, words per beat.
TAG_WIDTH, 2, tag bits per word; must be >= 2.
LEN_WIDTH, 8, out_len width; must hold 2*NUM_DATA.
STAT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
cfg_bypass  in  1  1 = emit every word raw; sampled at input handshake
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  DATA_WIDTH*NUM_DATA  words; word i at [i*DATA_WIDTH +: DATA_WIDTH]
in_ref  in  DATA_WIDTH*NUM_DATA  reference words, same layout
in_last  in  1  end-of-frame marker, carried through
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH*NUM_DATA  compacted payload, LSB-first
out_tag  out  TAG_WIDTH*NUM_DATA  tag i at [i*TAG_WIDTH +: TAG_WIDTH]
out_len  out  LEN_WIDTH  payload length in half-words (DATA_WIDTH/2 units)
out_last  out  1  in_last of this beat
stat_clr  in  1  synchronous clear of statistics
stat_beats  out  STAT_WIDTH  output beats handshaken
stat_halves  out  STAT_WIDTH  sum of out_len over handshaken beats

Behaviour:
- Tag encoding, priority top-down per word w with reference r. Tag 0 (ZERO): w==0, 0 halves. Tag 1 (MATCH): w==r, 0 halves. Tag 2 (HALF): upper halves equal, emits lower half, 1 half. Tag 3 (RAW): otherwise, emits the full word, 2 halves. w==r==0 gives ZERO. Tag bits above bit 1 are 0.
- Bypass: every tag is RAW, out_len=2*NUM_DATA, out_data=in_data.
- Compaction: words are processed 0..NUM_DATA-1. Each word's payload is placed at the half-word offset equal to the prefix sum of the preceding words' halves. A RAW word is placed contiguously, low half first. out_data bits at and above out_len halves are 0.
- Pipeline: S1 registers tags, candidate halves and per-word half counts. S2 registers the compacted beat.
- Latency: 2 cycles from input handshake to out_valid when out_ready is held high. Throughput: 1 beat per cycle.
- Handshake readies:
  - s2_ready = !s2_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready
  - The ready path is combinational and allowed.
- Data stability: out_* stays stable while out_valid & !out_ready. No beat is dropped or duplicated, and order is preserved.
- Reset (asynchronous assert, synchronous-safe release):
  - s1_valid, s2_valid, out_valid = 0; out_data, out_tag, out_len, out_last = 0.
  - Counters = 0.
  - Beats in flight are discarded; reset mid-operation needs no flush.
  - in_ready = 1 after reset.
- Statistics:
  - Both counters update on out_valid & out_ready.
  - Both saturate at all-ones.
  - stat_clr has priority: a same-cycle handshake is not counted and the counter reads 0 next cycle.
- Empty pipe: out_valid=0, and out_* hold their last values.

Decomposition:
- Package compress_pkg holds: tag localparams TAG_ZERO=0, TAG_MATCH=1, TAG_HALF=2, TAG_RAW=3, and a function computing halves-per-tag.
- Sub-module word_classifier (one word: w, r, bypass -> tag, half count, payload) is instantiated NUM_DATA times via generate.
- Prefix-sum and compaction mux stay in compress_pipe.

Test Plan:
- All in_data=0, in_ref arbitrary, bypass=0 -> 2 cycles later out_tag=0x0000, out_len=0, out_data=0.
- in_data==in_ref, all words 0xA5A5A5A5 -> out_tag=0x5555, out_len=0.
- Case: word0=0x12345678, ref0=0x1234FFFF; word1=0xDEADBEEF, ref1=0; other words 0. Expected: out_tag=0x000E, out_len=3, out_data[15:0]=0x5678, out_data[47:16]=0xDEADBEEF, rest 0.
- bypass=1, in_data=0 -> out_tag=0xFFFF, out_len=16, out_data=0.
- Stream 4 beats with out_ready=0 for 5 cycles. Expected: in_ready=0 after 2 accepted beats, outputs stable; on release all 4 beats exit in order with out_last on beat 4 only.
- Handshake 3 beats of len 3 -> stat_beats=3, stat_halves=9. Then stat_clr during a handshake -> both 0. Then reset=0 mid-stream -> out_valid=0 immediately, counters 0.
